// File: rtl/seg7_scan.sv
// seg7_scan: multiplexed seven-segment scanner.
// The slow square wave from the upstream clock divider is synchronised and
// edge-detected into a one-cycle scan tick. Each tick moves to the next digit,
// with one blank cycle between digits. Display data is double-buffered and
// only swapped at the frame wrap, so a new value is never shown half-updated.
module seg7_scan #(
    parameter int DIGITS      = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SCAN_IN,
    input  logic [4*DIGITS-1:0]   VALUE,
    input  logic [DIGITS-1:0]     DP,
    input  logic                  LOAD,
    input  logic                  BLANK_LZ,
    output logic [DIGITS-1:0]     AN,
    output logic [6:0]            SEG,
    output logic                  SEG_DP,
    output logic                  FRAME
);

    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(DIGITS - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_DRIVE = 2'd2;

    // Segment patterns {g,f,e,d,c,b,a}, active-low.
    function automatic logic [6:0] decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            4'd15:   s = 7'b0111111;  // dash
            default: s = 7'b1111111;  // 10..14 blank
        endcase
        return s;
    endfunction

    // ------------------------------------------------------------------
    // Scan reference synchroniser and rising-edge detect
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   hist_q;
    logic                   tick;
    logic                   wrap;

    // Shift SCAN_IN through the synchroniser; the history flop remembers the
    // previous synchronised level so only a low-to-high transition ticks.
    always_ff @(posedge CLK) begin
        if (RST) begin
            sync_q <= '0;
            hist_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], SCAN_IN};
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign tick = sync_q[SYNC_STAGES-1] & ~hist_q;

    // ------------------------------------------------------------------
    // Digit index
    // ------------------------------------------------------------------
    logic [IW-1:0] idx_q, idx_d;

    assign wrap = tick && (idx_q == LAST_IDX);

    // Advance one digit per tick, wrapping after the last digit.
    always_comb begin
        idx_d = idx_q;
        if (tick) begin
            idx_d = wrap ? '0 : idx_q + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Double buffer: pending takes every LOAD, active only changes at wrap.
    // A LOAD coinciding with the wrap goes straight through to active.
    // ------------------------------------------------------------------
    logic [4*DIGITS-1:0] pend_val_q, pend_val_d;
    logic [DIGITS-1:0]   pend_dp_q,  pend_dp_d;
    logic [4*DIGITS-1:0] act_val_q,  act_val_d;
    logic [DIGITS-1:0]   act_dp_q,   act_dp_d;

    // Next-state for both buffers.
    always_comb begin
        pend_val_d = LOAD ? VALUE : pend_val_q;
        pend_dp_d  = LOAD ? DP    : pend_dp_q;
        act_val_d  = wrap ? pend_val_d : act_val_q;
        act_dp_d   = wrap ? pend_dp_d  : act_dp_q;
    end

    // ------------------------------------------------------------------
    // Scan state machine
    // ------------------------------------------------------------------
    logic [1:0] state_q, state_d;

    // Any tick forces a blank cycle; BLANK otherwise always proceeds to DRIVE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  state_d = tick ? ST_BLANK : ST_IDLE;
            ST_BLANK: state_d = tick ? ST_BLANK : ST_DRIVE;
            ST_DRIVE: state_d = tick ? ST_BLANK : ST_DRIVE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Per-digit decode with leading-zero blanking
    // ------------------------------------------------------------------
    logic [DIGITS-1:0]      lz_blank;
    logic [DIGITS-1:0][6:0] dig_seg;

    // Walk from the most significant digit down; a digit is a leading zero
    // while it and everything above it are zero. Digit 0 always shows.
    always_comb begin
        logic zrun;
        zrun     = 1'b1;
        lz_blank = '0;
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zrun        = zrun && (act_val_d[4*i +: 4] == 4'd0);
            lz_blank[i] = BLANK_LZ && zrun && (i != 0);
        end
    end

    for (genvar g = 0; g < DIGITS; g++) begin : g_dig
        assign dig_seg[g] = lz_blank[g] ? 7'h7F : decode(act_val_d[4*g +: 4]);
    end

    // ------------------------------------------------------------------
    // Registered outputs, computed from next-state so the display follows
    // the state machine without an extra cycle of lag.
    // ------------------------------------------------------------------
    logic [DIGITS-1:0] an_d;
    logic [6:0]        seg_d;
    logic              dp_d;

    // Only DRIVE lights a digit; IDLE and BLANK keep everything dark.
    always_comb begin
        an_d  = '1;
        seg_d = 7'h7F;
        dp_d  = 1'b1;
        if (state_d == ST_DRIVE) begin
            an_d  = ~(DIGITS'(1) << idx_d);
            seg_d = dig_seg[idx_d];
            dp_d  = ~act_dp_d[idx_d];
        end
    end

    // All architectural state; RST overrides tick and LOAD.
    always_ff @(posedge CLK) begin
        if (RST) begin
            idx_q      <= '0;
            state_q    <= ST_IDLE;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            AN         <= '1;
            SEG        <= 7'h7F;
            SEG_DP     <= 1'b1;
            FRAME      <= 1'b0;
        end else begin
            idx_q      <= idx_d;
            state_q    <= state_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            AN         <= an_d;
            SEG        <= seg_d;
            SEG_DP     <= dp_d;
            FRAME      <= wrap;
        end
    end

endmodule
